ebr_stream_reader: RTL and testbench



---
 rtl/ebr_stream_reader_if.sv | 31 +++
 rtl/ebr_stream_reader.sv | 135 +++++++++++++
 tb/tb_ebr_stream_reader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebr_stream_reader_if.sv
// Bundle of signals between the EBR stream reader, its control agent, the block RAM read port and the downstream stream.
// The master view belongs to the reader; the slave view is the surrounding environment.
interface ebr_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int LEN_WIDTH  = $clog2(SIZE + 1)
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  start, start_addr, length, mem_rd_data, m_ready,
    output busy, done, mem_rd_en, mem_rd_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_addr, length, mem_rd_data, m_ready,
    input  busy, done, mem_rd_en, mem_rd_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ebr_stream_reader.sv
// Streams a contiguous (wrapping) region of a one-cycle-latency block RAM out as a valid/ready stream,
// absorbing read latency and backpressure in a 2-entry skid FIFO with a fall-through path.
module ebr_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int LEN_WIDTH  = $clog2(SIZE + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  ebr_stream_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, FINISH} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LEN_WIDTH-1:0]  eff_len_q;
  logic [LEN_WIDTH-1:0]  eff_len_d;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  sent_q;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;

  logic                  head_vld;
  logic                  pop;
  logic                  pop_head;
  logic                  push;
  logic                  rd_en;
  logic                  last_sent;
  logic                  last_pop;
  logic [2:0]            occ;

  assign eff_len_d = (bus.length > LEN_WIDTH'(SIZE)) ? LEN_WIDTH'(SIZE) : bus.length;
  assign addr_d    = (addr_q == ADDR_WIDTH'(SIZE - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  // Data returning from memory is presented directly when the FIFO is empty,
  // so the first beat is visible in the same cycle it arrives.
  assign head_vld  = (count_q != 2'd0);
  assign pop       = bus.m_valid & bus.m_ready;
  assign pop_head  = pop & head_vld;
  assign push      = inflight_q & ~(pop & ~head_vld);
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop_head};

  assign occ       = {1'b0, count_q} + {2'b0, inflight_q};
  assign rd_en     = (state_q == READ) && (issued_q < eff_len_q) && (occ < (3'd2 + {2'b0, pop}));
  assign last_sent = (sent_q == (eff_len_q - LEN_WIDTH'(1)));
  assign last_pop  = pop & last_sent;

  assign bus.m_valid     = head_vld | inflight_q;
  assign bus.m_data      = head_vld ? fifo_q[rd_ptr_q] : (inflight_q ? bus.mem_rd_data : '0);
  assign bus.m_last      = bus.m_valid & last_sent;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      eff_len_q  <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        addr_q   <= addr_d;
        issued_q <= issued_q + LEN_WIDTH'(1);
      end
      if (pop) sent_q <= sent_q + LEN_WIDTH'(1);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q    <= bus.start_addr;
            eff_len_q <= eff_len_d;
            issued_q  <= '0;
            sent_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= (eff_len_d == '0) ? FINISH : READ;
          end
        end
        READ: begin
          if (last_pop) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          // Arriving from READ, done is already up; an empty request raises it here instead.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (pop_head) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.mem_rd_data;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == 2'd2) && !pop_head));

endmodule

// File: tb/tb_ebr_stream_reader.sv
// Randomized self-checking bench for ebr_stream_reader: a memory model feeds the reader and each
// accepted beat is compared against mem[(start_addr + k) % SIZE] for k < min(length, SIZE).
module tb_ebr_stream_reader;
  localparam int DATA_WIDTH = 8;
  localparam int SIZE       = 32;
  localparam int ADDR_WIDTH = $clog2(SIZE);
  localparam int LEN_WIDTH  = $clog2(SIZE + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ebr_stream_reader_if #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) bus ();
  ebr_stream_reader #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));

  logic [DATA_WIDTH-1:0] mem [SIZE];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_WIDTH-1:0] got_q [$];
  bit                    lst_q [$];
  int                    bcyc_q [$];
  int rd_count, done_cycle, stable_err, proto_err, first_rd_cycle;
  bit busy1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_mem(input bit identity);
    for (int i = 0; i < SIZE; i++) mem[i] = identity ? DATA_WIDTH'(i) : DATA_WIDTH'($urandom);
  endtask

  task automatic start_frame(input int addr, input int len);
    bus.start      = 1'b1;
    bus.start_addr = ADDR_WIDTH'(addr);
    bus.length     = LEN_WIDTH'(len);
    tick();
    bus.start      = 1'b0;
  endtask

  // Observes up to max_cyc cycles of a frame; mode 0 ready high, 1 random, 2 random with a 5-cycle stall.
  task automatic collect(input int max_cyc, input int mode, input int inj_cyc);
    logic [DATA_WIDTH-1:0] prev_data;
    bit prev_last, prev_stall;
    got_q.delete(); lst_q.delete(); bcyc_q.delete();
    rd_count = 0; done_cycle = -1; stable_err = 0; proto_err = 0; first_rd_cycle = -1; busy1 = 0;
    prev_stall = 0; prev_data = '0; prev_last = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ($urandom_range(0, 1) != 0);
        default: bus.m_ready = (c >= 4 && c <= 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
      endcase
      bus.start = (c == inj_cyc);
      if (c == inj_cyc) begin
        bus.start_addr = ADDR_WIDTH'(17);
        bus.length     = LEN_WIDTH'(3);
      end
      #1;
      if (c == 1) busy1 = bus.busy;
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        stable_err++;
      if (rd_count - got_q.size() > 2) proto_err++;
      if (bus.mem_rd_en) begin
        if (rd_count == 0) first_rd_cycle = c;
        if (!bus.busy) proto_err++;
        rd_count++;
      end
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        lst_q.push_back(bus.m_last);
        bcyc_q.push_back(c);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.done) begin
        done_cycle = c;
        if (bus.busy) proto_err++;
        tick();
        bus.start = 1'b0;
        break;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  function automatic int seq_errs(input int addr, input int len);
    int e = (len > SIZE) ? SIZE : len;
    int errs = (got_q.size() != e) ? 1 : 0;
    for (int k = 0; k < e && k < got_q.size(); k++) begin
      if (got_q[k] !== mem[(addr + k) % SIZE]) errs++;
      if (lst_q[k] !== (k == e - 1)) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last} !== 5'b0) begin
      $display("FAIL reset_ctrl: observed %b, expected 00000",
               {bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last});
      n_err++;
    end
    n_vec++;
    if (bus.m_data !== '0 || bus.mem_rd_addr !== '0) begin
      $display("FAIL reset_data: m_data %0h addr %0d, expected 0 0", bus.m_data, bus.mem_rd_addr);
      n_err++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int e;
    fill_mem(1);
    start_frame(4, 5);
    collect(40, 0, 0);
    e = seq_errs(4, 5);
    n_vec++;
    if (e !== 0) begin $display("FAIL basic_seq: observed %0d errors, expected 0", e); n_err++; end
    n_vec++;
    if (bcyc_q.size() != 5 || bcyc_q[0] !== 2 || bcyc_q[4] !== 6) begin
      $display("FAIL basic_beat_cycles: observed %0d beats, expected beats on cycles 2..6", bcyc_q.size());
      n_err++;
    end
    n_vec++;
    if (done_cycle !== 7) begin $display("FAIL basic_done: observed %0d, expected 7", done_cycle); n_err++; end
    n_vec++;
    if (rd_count !== 5) begin $display("FAIL basic_reads: observed %0d, expected 5", rd_count); n_err++; end
    n_vec++;
    if (first_rd_cycle !== 1 || busy1 !== 1'b1) begin
      $display("FAIL basic_first_read: observed cycle %0d busy %0d, expected 1 1", first_rd_cycle, busy1);
      n_err++;
    end
  endtask

  task automatic test_wrap();
    int e;
    fill_mem(1);
    start_frame(30, 4);
    collect(40, 0, 0);
    e = seq_errs(30, 4);
    n_vec++;
    if (e !== 0) begin $display("FAIL wrap_seq: observed %0d errors, expected 0", e); n_err++; end
    n_vec++;
    if (done_cycle !== 6) begin $display("FAIL wrap_done: observed %0d, expected 6", done_cycle); n_err++; end
  endtask

  task automatic test_backpressure();
    int e;
    fill_mem(1);
    start_frame(0, 8);
    collect(200, 2, 0);
    e = seq_errs(0, 8);
    n_vec++;
    if (e !== 0) begin $display("FAIL bp_seq: observed %0d errors, expected 0", e); n_err++; end
    n_vec++;
    if (stable_err !== 0) begin $display("FAIL bp_stable: observed %0d, expected 0", stable_err); n_err++; end
    n_vec++;
    if (proto_err !== 0) begin $display("FAIL bp_occupancy: observed %0d, expected 0", proto_err); n_err++; end
    n_vec++;
    if (rd_count !== 8 || done_cycle < 0) begin
      $display("FAIL bp_reads: observed reads %0d done %0d, expected 8 and a done", rd_count, done_cycle);
      n_err++;
    end
  endtask

  task automatic test_zero_and_clamp();
    int e;
    fill_mem(0);
    start_frame(7, 0);
    collect(20, 0, 0);
    n_vec++;
    if (rd_count !== 0 || got_q.size() !== 0) begin
      $display("FAIL zero_len_activity: reads %0d beats %0d, expected 0 0", rd_count, got_q.size());
      n_err++;
    end
    n_vec++;
    if (done_cycle !== 2) begin $display("FAIL zero_len_done: observed %0d, expected 2", done_cycle); n_err++; end
    start_frame(11, 40);
    collect(100, 0, 0);
    e = seq_errs(11, 40);
    n_vec++;
    if (e !== 0 || rd_count !== 32) begin
      $display("FAIL clamp: observed %0d errors %0d reads, expected 0 32", e, rd_count);
      n_err++;
    end
    n_vec++;
    if (done_cycle !== 34) begin $display("FAIL clamp_done: observed %0d, expected 34", done_cycle); n_err++; end
  endtask

  task automatic test_start_ignored();
    int e;
    fill_mem(0);
    start_frame(2, 10);
    collect(100, 1, 3);
    e = seq_errs(2, 10);
    n_vec++;
    if (e !== 0 || rd_count !== 10) begin
      $display("FAIL restart_ignored: observed %0d errors %0d reads, expected 0 10", e, rd_count);
      n_err++;
    end
    collect(6, 0, 0);
    n_vec++;
    if (rd_count !== 0 || done_cycle !== -1) begin
      $display("FAIL restart_idle: reads %0d done %0d, expected 0 -1", rd_count, done_cycle);
      n_err++;
    end
  endtask

  task automatic test_abort();
    int e;
    fill_mem(0);
    start_frame(2, 12);
    collect(5, 0, 0);
    rst_n = 1'b0;
    tick();
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last} !== 5'b0 ||
        bus.m_data !== '0 || bus.mem_rd_addr !== '0) begin
      $display("FAIL abort_outputs: ctrl %b data %0h addr %0d, expected all 0",
               {bus.busy, bus.done, bus.mem_rd_en, bus.m_valid, bus.m_last}, bus.m_data, bus.mem_rd_addr);
      n_err++;
    end
    rst_n = 1'b1;
    tick();
    collect(8, 0, 0);
    n_vec++;
    if (done_cycle !== -1 || rd_count !== 0 || got_q.size() !== 0) begin
      $display("FAIL abort_quiet: done %0d reads %0d beats %0d, expected -1 0 0", done_cycle, rd_count, got_q.size());
      n_err++;
    end
    start_frame(9, 6);
    collect(30, 0, 0);
    e = seq_errs(9, 6);
    n_vec++;
    if (e !== 0 || done_cycle !== 8) begin
      $display("FAIL abort_restart: observed %0d errors done %0d, expected 0 8", e, done_cycle);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    int addr, len, eff, e, exp_done;
    for (int f = 0; f < 20; f++) begin
      fill_mem(0);
      addr = $urandom_range(0, SIZE - 1);
      len  = $urandom_range(0, 40);
      eff  = (len > SIZE) ? SIZE : len;
      start_frame(addr, len);
      collect(400, $urandom_range(0, 1), 0);
      e = seq_errs(addr, len);
      exp_done = (eff == 0) ? 2 : ((bcyc_q.size() > 0) ? bcyc_q[bcyc_q.size() - 1] + 1 : -2);
      n_vec++;
      if (e !== 0 || rd_count !== eff) begin
        $display("FAIL b2b_seq[%0d]: addr %0d len %0d errors %0d reads %0d, expected 0 errors %0d reads",
                 f, addr, len, e, rd_count, eff);
        n_err++;
      end
      n_vec++;
      if (done_cycle !== exp_done || stable_err !== 0 || proto_err !== 0) begin
        $display("FAIL b2b_proto[%0d]: done %0d stable %0d proto %0d, expected done %0d 0 0",
                 f, done_cycle, stable_err, proto_err, exp_done);
        n_err++;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_clamp();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
